menu_selector: RTL and testbench
================================

# menu_selector

Parametrised menu navigation FSM for the drink-machine front panel: N_OPT selectable options, browse with next/prev buttons, select to enter a serving state, leave it by clear or automatic timeout. The block is the generalised menu controller that sits between the debounced panel buttons and the dispense/display logic. Buttons are edge-detected internally, so a held button acts once. An enable input parks the machine in an OFF state.

## Interface
- N_OPT, 4: number of menu options, range 2..256.
- IDXW, $clog2(N_OPT): width of the cursor index (derived, not overridden).
- WRAP, 0: 1 means next on the last option goes to option 0 and prev on option 0 goes to the last; 0 means both saturate.
- SERVE_CYCLES, 16: serving-state timeout in clk cycles, range 0..65535; 0 means no timeout.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clock clk
- en  in  1  machine enable (level); 0 forces OFF
- next_btn  in  1  advance cursor (level, synchronous, debounced upstream)
- prev_btn  in  1  move cursor back
- sel_btn  in  1  select current option
- clr_btn  in  1  leave serving state
- cursor  out  IDXW  current option index
- sel_onehot  out  N_OPT  one-hot of selected option, nonzero only in SERVE
- serving  out  1  high in SERVE
- off  out  1  high in OFF
- done  out  1  one-cycle pulse when SERVE ends by timeout

## Operation
- States: OFF, BROWSE, SERVE. Encoded internally; only the outputs are architectural.
- Edge detect: each button has a registered previous sample, reset to 0. An event is btn & ~btn_q. A button that is high at reset release does not count as an event until it falls and rises again.
- Reset: state BROWSE, cursor 0, timer 0, all btn_q 0, sel_onehot 0, serving 0, off 0, done 0.
- en=0 in any state: the next state is OFF and cursor is cleared to 0. This has top priority and overrides all events and the timeout. In OFF, every event is ignored; btn_q still tracks the inputs.
- OFF to BROWSE: on the first clock with en=1, with cursor 0. Any event in that same cycle is ignored.
- BROWSE, one action per cycle, priority next > prev > sel:
  - next: cursor+1. At N_OPT-1 the cursor goes to 0 if WRAP=1, otherwise it stays.
  - prev: cursor-1. At 0 the cursor goes to N_OPT-1 if WRAP=1, otherwise it stays.
  - sel: go to SERVE, load the timer with 0, and hold the cursor.
- SERVE:
  - The cursor is frozen, and next/prev/sel events are ignored.
  - On clr event: go to BROWSE with cursor 0; no done pulse.
  - Otherwise, if SERVE_CYCLES>0, the timer increments every cycle. When the timer equals SERVE_CYCLES-1, the state goes to BROWSE with cursor 0 and done pulses.
  - If clr and the timeout coincide, the clr path is taken: no done pulse.
- A clr event in BROWSE or OFF has no effect.
- Outputs are decoded from registered state:
  - sel_onehot = 1<<cursor when serving, else 0.
  - done is a registered pulse.

## Timing
- Button-to-state latency: a button sampled high at edge k, while btn_q is low, updates the state and cursor at edge k. The new outputs are visible after edge k.
- SERVE dwell with no clr: exactly SERVE_CYCLES cycles of serving=1 after the sel edge.
  - done is high in the first cycle after serving falls, and for exactly 1 cycle.
- en falling at edge k: off=1, serving=0 and cursor=0 after edge k, whatever the state. Edge k does not produce a done pulse.
- Asynchronous reset mid-SERVE: all outputs return to their reset values immediately, with no done pulse.
- Timer width is 16 bits. Timer and cursor never exceed their ranges; no arithmetic overflow is permitted.

## Test plan
- Reset, then 5 next pulses with N_OPT=4, WRAP=0 -> cursor 1,2,3,3,3. Repeat with WRAP=1 -> cursor 1,2,3,0,1. Prev from 0 with WRAP=1 -> 3.
- next held high for 10 cycles -> cursor increments exactly once. next and prev rising in the same cycle -> cursor+1 only.
- cursor=2, sel pulse, SERVE_CYCLES=16 -> serving=1 and sel_onehot=4'b0100 for 16 cycles, then serving=0, cursor=0, done=1 for 1 cycle.
- In SERVE, next/sel pulses -> no change. clr at cycle 5 -> BROWSE with cursor 0, done stays 0. clr coinciding with the timeout cycle -> done=0.
- en=0 mid-SERVE -> off=1, serving=0, cursor=0 the next cycle, buttons ignored. en=1 -> BROWSE with cursor 0, and an event in that cycle is ignored.
- Async reset asserted between clock edges during SERVE -> outputs cleared immediately. A button held through the reset release produces no event.

Source files
------------

// File: rtl/menu_selector_if.sv
// menu_selector_if: panel buttons in, cursor/selection/status out
//   master: drives en and the four buttons, observes cursor, sel_onehot, serving, off, done
//   slave : the menu controller side
interface menu_selector_if #(
  parameter int N_OPT = 4
) ();
  localparam int IDXW = $clog2(N_OPT);
  logic en;
  logic next_btn;
  logic prev_btn;
  logic sel_btn;
  logic clr_btn;
  logic [IDXW-1:0] cursor;
  logic [N_OPT-1:0] sel_onehot;
  logic serving;
  logic off;
  logic done;
  modport master (
    output en, next_btn, prev_btn, sel_btn, clr_btn,
    input  cursor, sel_onehot, serving, off, done
  );
  modport slave (
    input  en, next_btn, prev_btn, sel_btn, clr_btn,
    output cursor, sel_onehot, serving, off, done
  );
endinterface

// File: rtl/menu_selector.sv
// menu_selector: drink-machine menu FSM (OFF/BROWSE/SERVE) with edge-detected buttons and serve timeout
//   clk, reset (async, active-high)
//   bus.en/next_btn/prev_btn/sel_btn/clr_btn in; bus.cursor/sel_onehot/serving/off/done out
module menu_selector #(
  parameter int N_OPT = 4,
  parameter bit WRAP = 1'b0,
  parameter int SERVE_CYCLES = 16,
  localparam int IDXW = $clog2(N_OPT)
) (
  input logic clk,
  input logic reset,
  menu_selector_if.slave bus
);
  typedef enum logic [1:0] {OFF, BROWSE, SERVE} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(N_OPT - 1);
  localparam logic [15:0] T_LAST = 16'(SERVE_CYCLES == 0 ? 0 : SERVE_CYCLES - 1);
  state_t state, state_n;
  logic [IDXW-1:0] cursor, cursor_n;
  logic [15:0] timer, timer_n;
  logic done_q, done_n;
  logic live;
  logic [3:0] btn, btn_q, ev;
  assign btn = {bus.clr_btn, bus.sel_btn, bus.prev_btn, bus.next_btn};
  // live masks the first edge after reset so a button held through release is not an event
  assign ev = live ? (btn & ~btn_q) : 4'b0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BROWSE;
      cursor <= '0;
      timer  <= '0;
      btn_q  <= '0;
      done_q <= 1'b0;
      live   <= 1'b0;
    end else begin
      state  <= state_n;
      cursor <= cursor_n;
      timer  <= timer_n;
      btn_q  <= btn;
      done_q <= done_n;
      live   <= 1'b1;
    end
  end
  always_comb begin
    state_n  = state;
    cursor_n = cursor;
    timer_n  = timer;
    done_n   = 1'b0;
    if (!bus.en) begin
      state_n  = OFF;
      cursor_n = '0;
      timer_n  = '0;
    end else if (state == OFF) begin
      state_n  = BROWSE;
      cursor_n = '0;
    end else if (state == BROWSE) begin
      if (ev[0]) cursor_n = (cursor == LAST) ? (WRAP ? '0 : cursor) : cursor + 1'b1;
      else if (ev[1]) cursor_n = (cursor == '0) ? (WRAP ? LAST : cursor) : cursor - 1'b1;
      else if (ev[2]) begin
        state_n = SERVE;
        timer_n = '0;
      end
    end else if (ev[3]) begin
      state_n  = BROWSE;
      cursor_n = '0;
    end else if (SERVE_CYCLES > 0) begin
      if (timer == T_LAST) begin
        state_n  = BROWSE;
        cursor_n = '0;
        done_n   = 1'b1;
      end else timer_n = timer + 1'b1;
    end
  end
  assign bus.cursor     = cursor;
  assign bus.serving    = (state == SERVE);
  assign bus.off        = (state == OFF);
  assign bus.done       = done_q;
  assign bus.sel_onehot = (state == SERVE) ? (N_OPT'(1) << cursor) : '0;
endmodule

// File: tb/tb_menu_selector.sv
// tb_menu_selector: directed checks of menu_selector with WRAP=0 (u0) and WRAP=1 (u1) side by side
module tb_menu_selector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1, nb = 1'b0, pb = 1'b0, sb = 1'b0, cb = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  menu_selector_if #(.N_OPT(4)) b0 ();
  menu_selector_if #(.N_OPT(4)) b1 ();
  assign b0.en = en;
  assign b0.next_btn = nb;
  assign b0.prev_btn = pb;
  assign b0.sel_btn = sb;
  assign b0.clr_btn = cb;
  assign b1.en = en;
  assign b1.next_btn = nb;
  assign b1.prev_btn = pb;
  assign b1.sel_btn = sb;
  assign b1.clr_btn = cb;
  menu_selector #(.N_OPT(4), .WRAP(1'b0), .SERVE_CYCLES(16)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  menu_selector #(.N_OPT(4), .WRAP(1'b1), .SERVE_CYCLES(16)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    {en, nb, pb, sb, cb} = 5'b10000;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (b0.cursor !== 2'd0 || b0.serving !== 1'b0 || b0.off !== 1'b0 || b0.done !== 1'b0 || b0.sel_onehot !== 4'b0) begin
      errors++;
      $display("FAIL reset u0 got cursor=%0d serving=%0b off=%0b done=%0b onehot=%b want 0,0,0,0,0000", b0.cursor, b0.serving, b0.off, b0.done, b0.sel_onehot);
    end
    checks++;
    if (b1.cursor !== 2'd0 || b1.serving !== 1'b0 || b1.off !== 1'b0 || b1.done !== 1'b0) begin
      errors++;
      $display("FAIL reset u1 got cursor=%0d serving=%0b off=%0b done=%0b want 0,0,0,0", b1.cursor, b1.serving, b1.off, b1.done);
    end
  endtask
  task automatic test_wrap();
    int e0[5] = '{1, 2, 3, 3, 3};
    int e1[5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      nb = 1'b1;
      tick();
      checks++;
      if (b0.cursor !== 2'(e0[i])) begin
        errors++;
        $display("FAIL next_sat[%0d] got %0d want %0d", i, b0.cursor, e0[i]);
      end
      checks++;
      if (b1.cursor !== 2'(e1[i])) begin
        errors++;
        $display("FAIL next_wrap[%0d] got %0d want %0d", i, b1.cursor, e1[i]);
      end
      nb = 1'b0;
      tick();
    end
    do_reset();
    pb = 1'b1;
    tick();
    pb = 1'b0;
    checks++;
    if (b1.cursor !== 2'd3) begin
      errors++;
      $display("FAIL prev_wrap got %0d want 3", b1.cursor);
    end
    checks++;
    if (b0.cursor !== 2'd0) begin
      errors++;
      $display("FAIL prev_sat got %0d want 0", b0.cursor);
    end
    tick();
  endtask
  task automatic test_held();
    do_reset();
    nb = 1'b1;
    repeat (10) tick();
    checks++;
    if (b0.cursor !== 2'd1) begin
      errors++;
      $display("FAIL held_next got %0d want 1", b0.cursor);
    end
    nb = 1'b0;
    tick();
    nb = 1'b1;
    pb = 1'b1;
    tick();
    checks++;
    if (b0.cursor !== 2'd2) begin
      errors++;
      $display("FAIL next_prev_same got %0d want 2", b0.cursor);
    end
    nb = 1'b0;
    pb = 1'b0;
    tick();
  endtask
  task automatic test_serve();
    int bad = 0;
    do_reset();
    repeat (2) begin
      nb = 1'b1;
      tick();
      nb = 1'b0;
      tick();
    end
    sb = 1'b1;
    tick();
    sb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (b0.serving !== 1'b1 || b0.sel_onehot !== 4'b0100 || b0.done !== 1'b0 || b0.cursor !== 2'd2) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL serve_dwell got %0d bad cycles want 0", bad);
    end
    checks++;
    if (b0.serving !== 1'b0 || b0.cursor !== 2'd0 || b0.done !== 1'b1 || b0.sel_onehot !== 4'b0) begin
      errors++;
      $display("FAIL serve_timeout got serving=%0b cursor=%0d done=%0b onehot=%b want 0,0,1,0000", b0.serving, b0.cursor, b0.done, b0.sel_onehot);
    end
    checks++;
    if (b1.serving !== 1'b0 || b1.done !== 1'b1) begin
      errors++;
      $display("FAIL serve_timeout_u1 got serving=%0b done=%0b want 0,1", b1.serving, b1.done);
    end
    tick();
    checks++;
    if (b0.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got %0b want 0", b0.done);
    end
  endtask
  task automatic test_serve_ignore();
    do_reset();
    nb = 1'b1;
    tick();
    nb = 1'b0;
    tick();
    sb = 1'b1;
    tick();
    sb = 1'b0;
    tick();
    nb = 1'b1;
    tick();
    nb = 1'b0;
    sb = 1'b1;
    tick();
    sb = 1'b0;
    checks++;
    if (b0.cursor !== 2'd1 || b0.serving !== 1'b1 || b0.sel_onehot !== 4'b0010) begin
      errors++;
      $display("FAIL serve_frozen got cursor=%0d serving=%0b onehot=%b want 1,1,0010", b0.cursor, b0.serving, b0.sel_onehot);
    end
    cb = 1'b1;
    tick();
    cb = 1'b0;
    checks++;
    if (b0.serving !== 1'b0 || b0.cursor !== 2'd0 || b0.done !== 1'b0) begin
      errors++;
      $display("FAIL clr_exit got serving=%0b cursor=%0d done=%0b want 0,0,0", b0.serving, b0.cursor, b0.done);
    end
    tick();
    checks++;
    if (b0.done !== 1'b0 || b0.serving !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_done got done=%0b serving=%0b want 0,0", b0.done, b0.serving);
    end
  endtask
  task automatic test_clr_timeout();
    do_reset();
    sb = 1'b1;
    tick();
    sb = 1'b0;
    repeat (15) tick();
    checks++;
    if (b0.serving !== 1'b1) begin
      errors++;
      $display("FAIL pre_timeout got serving=%0b want 1", b0.serving);
    end
    cb = 1'b1;
    tick();
    cb = 1'b0;
    checks++;
    if (b0.serving !== 1'b0 || b0.done !== 1'b0) begin
      errors++;
      $display("FAIL clr_timeout got serving=%0b done=%0b want 0,0", b0.serving, b0.done);
    end
    tick();
    checks++;
    if (b0.done !== 1'b0) begin
      errors++;
      $display("FAIL clr_timeout_after got done=%0b want 0", b0.done);
    end
  endtask
  task automatic test_enable();
    do_reset();
    nb = 1'b1;
    tick();
    nb = 1'b0;
    tick();
    sb = 1'b1;
    tick();
    sb = 1'b0;
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (b0.off !== 1'b1 || b0.serving !== 1'b0 || b0.cursor !== 2'd0 || b0.done !== 1'b0) begin
      errors++;
      $display("FAIL en_off got off=%0b serving=%0b cursor=%0d done=%0b want 1,0,0,0", b0.off, b0.serving, b0.cursor, b0.done);
    end
    nb = 1'b1;
    tick();
    nb = 1'b0;
    sb = 1'b1;
    tick();
    sb = 1'b0;
    checks++;
    if (b0.off !== 1'b1 || b0.cursor !== 2'd0 || b0.serving !== 1'b0) begin
      errors++;
      $display("FAIL off_ignore got off=%0b cursor=%0d serving=%0b want 1,0,0", b0.off, b0.cursor, b0.serving);
    end
    en = 1'b1;
    nb = 1'b1;
    tick();
    checks++;
    if (b0.off !== 1'b0 || b0.cursor !== 2'd0 || b0.serving !== 1'b0) begin
      errors++;
      $display("FAIL en_on got off=%0b cursor=%0d serving=%0b want 0,0,0", b0.off, b0.cursor, b0.serving);
    end
    nb = 1'b0;
    tick();
    nb = 1'b1;
    tick();
    nb = 1'b0;
    checks++;
    if (b0.cursor !== 2'd1) begin
      errors++;
      $display("FAIL browse_after_en got %0d want 1", b0.cursor);
    end
    tick();
  endtask
  task automatic test_async_reset();
    do_reset();
    nb = 1'b1;
    tick();
    nb = 1'b0;
    tick();
    sb = 1'b1;
    tick();
    sb = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    nb = 1'b1;
    #1;
    checks++;
    if (b0.serving !== 1'b0 || b0.cursor !== 2'd0 || b0.sel_onehot !== 4'b0 || b0.done !== 1'b0 || b0.off !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got serving=%0b cursor=%0d onehot=%b done=%0b off=%0b want 0,0,0000,0,0", b0.serving, b0.cursor, b0.sel_onehot, b0.done, b0.off);
    end
    tick();
    #3;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (b0.cursor !== 2'd0 || b1.cursor !== 2'd0) begin
      errors++;
      $display("FAIL held_through_reset got %0d/%0d want 0/0", b0.cursor, b1.cursor);
    end
    nb = 1'b0;
    tick();
    nb = 1'b1;
    tick();
    nb = 1'b0;
    checks++;
    if (b0.cursor !== 2'd1) begin
      errors++;
      $display("FAIL rearm_after_reset got %0d want 1", b0.cursor);
    end
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_wrap();
    test_held();
    test_serve();
    test_serve_ignore();
    test_clr_timeout();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
